// File: rtl/versal_dpr_pkg.sv
// Shared types and constants for the DPR responder: FSM states, tile geometry and spare pool location.
package versal_dpr_pkg;

  localparam int TILE_W     = 9;
  localparam int NUM_SPARES = 8;
  localparam int SPARE_BASE = 392;

  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_ALLOC,
    ST_RECONFIG,
    ST_VERIFY,
    ST_DONE,
    ST_FAIL
  } dpr_state_e;

endpackage

// File: rtl/dpr_spare_alloc.sv
// Spare tile pool: free mask, lowest-free pick and free count; a spare, once handed out, is never returned.
module dpr_spare_alloc
  import versal_dpr_pkg::*;
#(
  parameter int NUM_SPARES = versal_dpr_pkg::NUM_SPARES,
  localparam int IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
  localparam int CNT_W = $clog2(NUM_SPARES + 1)
) (
  input  logic             clk_650mhz,
  input  logic             rst_n,
  input  logic             alloc,
  output logic             any_free,
  output logic [IDX_W-1:0] free_idx,
  output logic [CNT_W-1:0] spares_left
);

  logic [NUM_SPARES-1:0] free_q, free_d;

  always_comb begin
    any_free    = |free_q;
    free_idx    = '0;
    spares_left = '0;
    // Descending scan so the lowest free index is the last one written.
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (free_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_SPARES; i++) begin
      spares_left = spares_left + CNT_W'(free_q[i]);
    end
    free_d = free_q;
    if (alloc && any_free) free_d[free_idx] = 1'b0;
  end

  always_ff @(posedge clk_650mhz) begin
    if (!rst_n) free_q <= '1;
    else        free_q <= free_d;
  end

endmodule

// File: rtl/versal_dpr_responder.sv
// SEFI healing responder: quiesce, optional spare relocation, partial reconfig with CRC check, completion report.
// DPR_RETRY_EN enables the bounded retry path after CRC fail or cfg_ack timeout; undefined means first failure is final.
module versal_dpr_responder
  import versal_dpr_pkg::*;
#(
  parameter int TILE_W      = versal_dpr_pkg::TILE_W,
  parameter int NUM_SPARES  = versal_dpr_pkg::NUM_SPARES,
  parameter int SPARE_BASE  = versal_dpr_pkg::SPARE_BASE,
  parameter int QUIESCE_CYC = 64,
  parameter int TIMEOUT_CYC = 6_500_000,
  parameter int MAX_RETRY   = 2,
  localparam int SPL_W = $clog2(NUM_SPARES + 1)
) (
  input  logic              clk_650mhz,
  input  logic              rst_n,
  input  logic              dpr_start,
  input  logic              ai_redundancy_shift,
  input  logic              veto,
  input  logic [TILE_W-1:0] fault_tile,
  output logic              cfg_req,
  output logic [TILE_W-1:0] cfg_tile,
  input  logic              cfg_ack,
  input  logic              crc_valid,
  input  logic              crc_ok,
  output logic              dpr_busy,
  output logic              dpr_done,
  output logic              dpr_fail,
  output logic              sefi_clear,
  output logic              remap_we,
  output logic [TILE_W-1:0] remap_src,
  output logic [TILE_W-1:0] remap_dst,
  output logic [SPL_W-1:0]  spares_left
);

  localparam int QW    = (QUIESCE_CYC > 1) ? $clog2(QUIESCE_CYC) : 1;
  localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;
`ifdef DPR_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  dpr_state_e        state_q, state_d;
  logic              start_q, start_d;
  logic              shift_q, shift_d;
  logic [TILE_W-1:0] fault_q, fault_d;
  logic [TILE_W-1:0] spare_q, spare_d;
  logic [TILE_W-1:0] cfg_tile_q, cfg_tile_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic              qarm_q, qarm_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              cfg_req_q, cfg_req_d;
  logic              enter_done_q, enter_done_d;
  logic              done_q, done_d;
  logic              remap_we_q, remap_we_d;
  logic [TILE_W-1:0] remap_src_q, remap_src_d;
  logic [TILE_W-1:0] remap_dst_q, remap_dst_d;
  logic              fail_q, fail_d;

  logic              alloc;
  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic              retry_take;
  logic              ack;
  logic              timeout;
  logic              retry_ok;
  logic [QW-1:0]     qcnt_eff;

  dpr_spare_alloc #(.NUM_SPARES(NUM_SPARES)) u_spare_alloc (
    .clk_650mhz  (clk_650mhz),
    .rst_n       (rst_n),
    .alloc       (alloc),
    .any_free    (any_free),
    .free_idx    (free_idx),
    .spares_left (spares_left)
  );

  // Acks and timeouts only count while the request is actually on the wire.
  assign ack      = cfg_req_q && cfg_ack;
  assign timeout  = cfg_req_q && (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign retry_ok = RETRY_EN && (retry_q < RW'(MAX_RETRY));
  // The first veto cycle already counts as a drain cycle.
  assign qcnt_eff = qarm_q ? qcnt_q : QW'(QUIESCE_CYC - 1);

  always_comb begin
    state_d      = state_q;
    start_d      = dpr_start;
    shift_d      = shift_q;
    fault_d      = fault_q;
    spare_d      = spare_q;
    cfg_tile_d   = cfg_tile_q;
    qcnt_d       = qcnt_q;
    qarm_d       = qarm_q;
    tmr_d        = '0;
    retry_d      = retry_q;
    fail_d       = fail_q;
    enter_done_d = 1'b0;
    done_d       = enter_done_q;
    remap_we_d   = enter_done_q && shift_q;
    remap_src_d  = remap_src_q;
    remap_dst_d  = remap_dst_q;
    alloc        = 1'b0;
    retry_take   = 1'b0;

    if (enter_done_q && shift_q) begin
      remap_src_d = fault_q;
      remap_dst_d = spare_q;
    end

    case (state_q)
      ST_IDLE: begin
        qarm_d = 1'b0;
        if (dpr_start && !start_q) begin
          shift_d = ai_redundancy_shift;
          fault_d = fault_tile;
          fail_d  = 1'b0;
          retry_d = '0;
          state_d = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (!veto) begin
          qarm_d = 1'b0;
        end else if (qcnt_eff == '0) begin
          qarm_d = 1'b0;
          if (shift_q) begin
            state_d = ST_ALLOC;
          end else begin
            cfg_tile_d = fault_q;
            state_d    = ST_RECONFIG;
          end
        end else begin
          qarm_d = 1'b1;
          qcnt_d = qcnt_eff - QW'(1);
        end
      end
      ST_ALLOC: begin
        if (any_free) begin
          alloc      = 1'b1;
          spare_d    = TILE_W'(SPARE_BASE) + TILE_W'(free_idx);
          cfg_tile_d = TILE_W'(SPARE_BASE) + TILE_W'(free_idx);
          state_d    = ST_RECONFIG;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_RECONFIG: begin
        if (ack) begin
          state_d = ST_VERIFY;
        end else if (timeout) begin
          retry_take = 1'b1;
        end else if (cfg_req_q) begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_VERIFY: begin
        if (crc_valid) begin
          if (crc_ok) begin
            state_d      = ST_DONE;
            enter_done_d = 1'b1;
          end else begin
            retry_take = 1'b1;
          end
        end
      end
      ST_DONE, ST_FAIL: begin
        if (!dpr_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (retry_take) begin
      if (retry_ok) begin
        retry_d = retry_q + RW'(1);
        state_d = ST_RECONFIG;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (state_d == ST_FAIL) fail_d = 1'b1;

    // A timeout retry stays in RECONFIG but drops the request for one cycle.
    cfg_req_d = (state_d == ST_RECONFIG) && !(state_q == ST_RECONFIG && timeout && !ack);
  end

  always_ff @(posedge clk_650mhz) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      shift_q      <= 1'b0;
      fault_q      <= '0;
      spare_q      <= '0;
      cfg_tile_q   <= '0;
      qcnt_q       <= '0;
      qarm_q       <= 1'b0;
      tmr_q        <= '0;
      retry_q      <= '0;
      cfg_req_q    <= 1'b0;
      enter_done_q <= 1'b0;
      done_q       <= 1'b0;
      remap_we_q   <= 1'b0;
      remap_src_q  <= '0;
      remap_dst_q  <= '0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      shift_q      <= shift_d;
      fault_q      <= fault_d;
      spare_q      <= spare_d;
      cfg_tile_q   <= cfg_tile_d;
      qcnt_q       <= qcnt_d;
      qarm_q       <= qarm_d;
      tmr_q        <= tmr_d;
      retry_q      <= retry_d;
      cfg_req_q    <= cfg_req_d;
      enter_done_q <= enter_done_d;
      done_q       <= done_d;
      remap_we_q   <= remap_we_d;
      remap_src_q  <= remap_src_d;
      remap_dst_q  <= remap_dst_d;
      fail_q       <= fail_d;
    end
  end

  assign cfg_req    = cfg_req_q;
  assign cfg_tile   = cfg_tile_q;
  assign dpr_busy   = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign dpr_done   = done_q;
  assign sefi_clear = done_q;
  assign remap_we   = remap_we_q;
  assign remap_src  = remap_src_q;
  assign remap_dst  = remap_dst_q;
  assign dpr_fail   = fail_q;

endmodule

// File: tb/tb_versal_dpr_responder.sv
// Scoreboard bench for versal_dpr_responder: expected outcomes queued per request, checked at dpr_done / dpr_fail.
module tb_versal_dpr_responder;
  import versal_dpr_pkg::*;

  localparam int QC = 64;
  localparam int TO = 1000;
`ifdef DPR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk_650mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       dpr_start = 1'b0;
  logic       ai_redundancy_shift = 1'b0;
  logic       veto = 1'b1;
  tile_t      fault_tile = '0;
  logic       cfg_ack = 1'b0;
  logic       crc_valid = 1'b0;
  logic       crc_ok = 1'b0;
  logic       cfg_req, dpr_busy, dpr_done, dpr_fail, sefi_clear, remap_we;
  tile_t      cfg_tile, remap_src, remap_dst;
  logic [3:0] spares_left;

  versal_dpr_responder #(.QUIESCE_CYC(QC), .TIMEOUT_CYC(TO)) dut (
    .clk_650mhz(clk_650mhz), .rst_n(rst_n), .dpr_start(dpr_start),
    .ai_redundancy_shift(ai_redundancy_shift), .veto(veto), .fault_tile(fault_tile),
    .cfg_req(cfg_req), .cfg_tile(cfg_tile), .cfg_ack(cfg_ack), .crc_valid(crc_valid),
    .crc_ok(crc_ok), .dpr_busy(dpr_busy), .dpr_done(dpr_done), .dpr_fail(dpr_fail),
    .sefi_clear(sefi_clear), .remap_we(remap_we), .remap_src(remap_src),
    .remap_dst(remap_dst), .spares_left(spares_left)
  );

  always #5 clk_650mhz = ~clk_650mhz;

  typedef struct {
    bit fail; bit remap; int tile; int src; int dst;
    int spares; int bursts; int lat; int blen;
  } exp_t;
  typedef struct { bit ack; int dly; bit ok; } att_t;

  exp_t sb_q[$];
  att_t att_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   ev_cnt = 0;

  always @(posedge clk_650mhz) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic add_att(input bit ack, input int dly, input bit ok);
    att_t a;
    a.ack = ack; a.dly = dly; a.ok = ok;
    att_q.push_back(a);
  endtask

  // Config port model: one queued behaviour per new cfg_req burst.
  initial begin : cfg_port
    bit   prev;
    att_t a;
    prev = 1'b0;
    forever begin
      @(negedge clk_650mhz);
      if (cfg_req && !prev && att_q.size() > 0) begin
        a = att_q.pop_front();
        if (a.ack) begin
          repeat (a.dly) @(posedge clk_650mhz);
          #1 cfg_ack = 1'b1;
          @(posedge clk_650mhz);
          #1 cfg_ack = 1'b0;
          repeat (2) @(posedge clk_650mhz);
          #1 crc_valid = 1'b1; crc_ok = a.ok;
          @(posedge clk_650mhz);
          #1 crc_valid = 1'b0; crc_ok = 1'b0;
          prev = 1'b0;
        end else begin
          prev = 1'b1;
        end
      end else begin
        prev = cfg_req;
      end
    end
  end

  initial begin : monitor
    int   bursts, first_tile, lat, blen, run, remap_cnt;
    bit   req_prev, fail_prev, is_fail;
    exp_t e;
    bursts = 0; first_tile = 0; lat = -1; blen = 0; run = 0; remap_cnt = 0;
    req_prev = 1'b0; fail_prev = 1'b0;
    forever begin
      @(negedge clk_650mhz);
      if (!rst_n) begin
        bursts = 0; run = 0; remap_cnt = 0; blen = 0; lat = -1;
        req_prev = 1'b0; fail_prev = 1'b0;
        continue;
      end
      if (cfg_req) begin
        if (!req_prev) begin
          bursts++;
          run = 0;
          if (bursts == 1) begin
            first_tile = int'(cfg_tile);
            lat = cyc - req_cyc;
          end
        end
        run++;
      end else if (req_prev && bursts == 1) begin
        blen = run;
      end
      req_prev = cfg_req;
      if (remap_we) remap_cnt++;
      if (dpr_done || (dpr_fail && !fail_prev)) begin
        is_fail = !dpr_done;
        check_val("sb_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("outcome_fail", is_fail, e.fail);
          check_val("bursts", bursts, e.bursts);
          if (e.bursts > 0) check_val("cfg_tile", first_tile, e.tile);
          if (e.lat >= 0) check_val("latency", lat, e.lat);
          if (e.blen > 0) check_val("burst_len", blen, e.blen);
          check_val("spares_left", spares_left, e.spares);
          check_val("remap_cnt", remap_cnt, e.remap);
          if (!is_fail) check_val("sefi_clear", sefi_clear, 1);
          if (e.remap) begin
            check_val("remap_src", remap_src, e.src);
            check_val("remap_dst", remap_dst, e.dst);
          end
        end
        ev_cnt++;
        bursts = 0; remap_cnt = 0; blen = 0; lat = -1;
      end
      fail_prev = dpr_fail;
    end
  end

  task automatic request(input bit shift, input int tile);
    @(posedge clk_650mhz);
    #1;
    ai_redundancy_shift = shift;
    fault_tile = tile_t'(tile);
    dpr_start = 1'b1;
    req_cyc = cyc;
  endtask

  task automatic run(input bit shift, input int tile, input bit fail, input bit remap,
                     input int ctile, input int dst, input int spares, input int bursts,
                     input int lat, input int blen, input int veto_at);
    exp_t e;
    int   s, n;
    e.fail = fail; e.remap = remap; e.tile = ctile; e.src = tile; e.dst = dst;
    e.spares = spares; e.bursts = bursts; e.lat = lat; e.blen = blen;
    sb_q.push_back(e);
    s = ev_cnt;
    if (veto_at >= 0) veto = 1'b0;
    request(shift, tile);
    repeat (2) @(negedge clk_650mhz);
    check_val("fail_cleared", dpr_fail, 0);
    check_val("busy_active", dpr_busy, 1);
    if (veto_at > 0) begin
      repeat (veto_at - 1) @(posedge clk_650mhz);
      #1 veto = 1'b1;
    end
    n = 0;
    while (ev_cnt == s && n < 4000) begin
      @(negedge clk_650mhz);
      n++;
    end
    check_val("txn_complete", ev_cnt != s, 1);
    @(negedge clk_650mhz);
    check_val("done_pulse", dpr_done, 0);
    @(posedge clk_650mhz);
    #1 dpr_start = 1'b0;
    repeat (3) @(posedge clk_650mhz);
    @(negedge clk_650mhz);
    check_val("fail_sticky", dpr_fail, fail);
    check_val("busy_idle", dpr_busy, 0);
    att_q.delete();
  endtask

  task automatic check_quiet(input string pfx);
    check_val({pfx, "_cfg_req"}, cfg_req, 0);
    check_val({pfx, "_cfg_tile"}, cfg_tile, 0);
    check_val({pfx, "_busy"}, dpr_busy, 0);
    check_val({pfx, "_done"}, dpr_done, 0);
    check_val({pfx, "_fail"}, dpr_fail, 0);
    check_val({pfx, "_sefi"}, sefi_clear, 0);
    check_val({pfx, "_remap_we"}, remap_we, 0);
    check_val({pfx, "_remap_src"}, remap_src, 0);
    check_val({pfx, "_remap_dst"}, remap_dst, 0);
    check_val({pfx, "_spares"}, spares_left, NUM_SPARES);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (2) @(posedge clk_650mhz);
    @(negedge clk_650mhz);
    check_quiet("reset");
    @(posedge clk_650mhz);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_650mhz);

    // Relocation to the first spare, ack after 100 cycles.
    add_att(1'b1, 100, 1'b1);
    run(1'b1, 17, 1'b0, 1'b1, 392, 392, 7, 1, 66, 101, -1);

    // In-place reconfig; veto arrives 10 cycles into QUIESCE.
    add_att(1'b1, 20, 1'b1);
    run(1'b0, 5, 1'b0, 1'b0, 5, 0, 7, 1, 74, 21, 10);

    // Two CRC failures then success.
    add_att(1'b1, 5, 1'b0);
    add_att(1'b1, 5, 1'b0);
    add_att(1'b1, 5, 1'b1);
    run(1'b0, 33, !RETRY, 1'b0, 33, 0, 7, RETRY ? 3 : 1, 65, 6, -1);

    // No ack: request must drop after exactly TO cycles.
    add_att(1'b0, 0, 1'b0);
    add_att(1'b1, 3, 1'b1);
    run(1'b0, 40, !RETRY, 1'b0, 40, 0, 7, RETRY ? 2 : 1, 65, TO, -1);

    // Drain the rest of the pool, including a fault on an already used spare.
    for (int i = 1; i < NUM_SPARES; i++) begin
      add_att(1'b1, 4, 1'b1);
      run(1'b1, (i == 3) ? 392 : 100 + i, 1'b0, 1'b1, 392 + i, 392 + i, 7 - i, 1, 66, 5, -1);
    end

    // Ninth shift: pool empty.
    run(1'b1, 200, 1'b1, 1'b0, 0, 0, 0, 0, -1, 0, -1);

    // Next request clears the sticky fail.
    add_att(1'b1, 4, 1'b1);
    run(1'b0, 7, 1'b0, 1'b0, 7, 0, 0, 1, 65, 5, -1);

    // Reset while RECONFIG is waiting for an ack.
    add_att(1'b0, 0, 1'b0);
    request(1'b0, 9);
    n = 0;
    while (!cfg_req && n < 200) begin
      @(negedge clk_650mhz);
      n++;
    end
    check_val("reached_reconfig", cfg_req, 1);
    @(posedge clk_650mhz);
    #1 rst_n = 1'b0; dpr_start = 1'b0;
    @(posedge clk_650mhz);
    @(negedge clk_650mhz);
    check_quiet("midrst");
    @(posedge clk_650mhz);
    #1 rst_n = 1'b1;
    att_q.delete();
    repeat (2) @(posedge clk_650mhz);

    // Pool restored: first spare again.
    add_att(1'b1, 4, 1'b1);
    run(1'b1, 21, 1'b0, 1'b1, 392, 392, 7, 1, 66, 5, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/versal_dpr_responder.md
# versal_dpr_responder

Responder side of the SEFI healing handshake. It accepts `dpr_start`/`ai_redundancy_shift` from the AGI healer, quiesces the faulty AIE tile and allocates a spare tile when a shift is requested. It then drives the partial-reconfiguration port, checks the readback CRC and reports completion back so the healer can release `veto`. It sits between the healer and the configuration/NoC remap fabric.

## Interface
- `TILE_W`, 9, tile index width (400 AIE tiles)
- `NUM_SPARES`, 8, spare tiles in pool
- `SPARE_BASE`, 392, tile index of spare 0; spare k = `SPARE_BASE`+k
- `QUIESCE_CYC`, 64, drain cycles after `veto` seen
- `TIMEOUT_CYC`, 6_500_000, `cfg_ack` timeout (10 ms at 650 MHz)
- `MAX_RETRY`, 2, reconfig retries after CRC fail/timeout

- `clk_650mhz` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `dpr_start` in 1: level request from healer
- `ai_redundancy_shift` in 1: sampled with request; 1 = relocate to spare, 0 = reconfigure in place
- `veto` in 1: healer veto; must be high before reconfig
- `fault_tile` in TILE_W: faulty tile, sampled with request
- `cfg_req` out 1: reconfig request, held until `cfg_ack` or timeout
- `cfg_tile` out TILE_W: tile being reconfigured
- `cfg_ack` in 1: config port done, single-cycle
- `crc_valid`, `crc_ok` in 1 each: readback result
- `dpr_busy` out 1: high outside IDLE/DONE/FAIL
- `dpr_done` out 1: one-cycle pulse on success
- `dpr_fail` out 1: sticky until next accepted request
- `sefi_clear` out 1: one-cycle pulse, coincident with `dpr_done`
- `remap_we` out 1: one-cycle remap table write
- `remap_src`, `remap_dst` out TILE_W: faulty tile, replacement tile
- `spares_left` out clog2(NUM_SPARES+1): free spares

## Operation
- States: IDLE, QUIESCE, ALLOC, RECONFIG, VERIFY, DONE, FAIL.
- IDLE: rising edge of `dpr_start` (registered previous value) captures `fault_tile`, `ai_redundancy_shift`; clears `dpr_fail`, retry count; goes to QUIESCE.
- QUIESCE: counter loads `QUIESCE_CYC`-1 on the first cycle `veto`=1 and counts down. At 0 it goes to ALLOC if shift=1, else to RECONFIG with `cfg_tile`=`fault_tile`. `veto` dropping restarts the count.
- ALLOC: lowest-index free spare chosen. None free -> FAIL. Otherwise mark used, decrement `spares_left`, `cfg_tile`=spare, go to RECONFIG. If `fault_tile` is itself a used spare, it stays marked used and is never freed.
- RECONFIG: `cfg_req`=1. `cfg_ack` -> VERIFY. Timeout counter reaching `TIMEOUT_CYC`-1 -> retry path. `cfg_req` deasserts the cycle after ack or timeout.
- VERIFY: wait `crc_valid`. `crc_ok`=1 -> DONE. `crc_ok`=0 -> retry path. VERIFY has no timeout.
- Retry path: retries < `MAX_RETRY` -> increment, back to RECONFIG with the same tile; else FAIL. The spare is not returned on fail.
- DONE: `dpr_done`, `sefi_clear` pulse once. `remap_we` pulses only if shift=1, with src=`fault_tile` and dst=spare. Wait for `dpr_start`=0, then IDLE.
- FAIL: `dpr_fail`=1. Wait for `dpr_start`=0, then IDLE.
- `dpr_start` rising in any non-IDLE state is ignored; deassert mid-operation does not abort.

## Timing
- Reset values: all outputs 0 except `spares_left`=`NUM_SPARES`. Pool all free, state IDLE.
- Reset mid-operation: immediate IDLE, pool restored to all free, remap writes not issued.
- Request edge at cycle 0 -> QUIESCE at cycle 1. With `veto` already high, RECONFIG or ALLOC entered at cycle 1+`QUIESCE_CYC`. ALLOC adds 1 cycle.
- `cfg_ack` and timeout in the same cycle: ack wins.
- `cfg_ack` seen outside RECONFIG is ignored.
- `dpr_done`, `sefi_clear`, `remap_we` are asserted in the cycle after entering DONE, all registered.
- Counters saturate and never wrap. Timeout counter is clog2(`TIMEOUT_CYC`) bits.

## Configuration
- `DPR_RETRY_EN` defined: retry path as above.
- Not defined: `MAX_RETRY` is ignored, and the first CRC fail or timeout goes to FAIL.

## Structure
- Package `versal_dpr_pkg`: state enum, `TILE_W`, `NUM_SPARES`, `SPARE_BASE` constants, tile typedef.
- Sub-module `dpr_spare_alloc`: free-mask register, lowest-free priority encoder, `any_free`, `spares_left` count, alloc strobe, synchronous reset to all-free.

## Test plan
- Shift=1, fault_tile=17, `veto` high, ack after 100 cycles, crc_ok=1 -> remap_src=17, remap_dst=392, `spares_left` 8->7, one `dpr_done`.
- Shift=0, fault_tile=5 -> `cfg_tile`=5, no `remap_we`, `spares_left` unchanged.
- Nine shift requests with success -> spares 392..399 used, ninth -> `dpr_fail`=1, `spares_left`=0.
- crc_ok=0 twice then 1 with `DPR_RETRY_EN` -> three `cfg_req` bursts, `dpr_done`. Without the macro: one burst, `dpr_fail`.
- No `cfg_ack` (TIMEOUT_CYC=1000) -> `cfg_req` drops at cycle 1000 of RECONFIG, retry or fail per macro.
- `rst_n`=0 during RECONFIG -> next cycle all outputs 0, `spares_left`=8.
